// File: rtl/datapath_seq_ctrl.sv
// Sequencer for y = (a<<14)/(a+b+c) * sin(d): latches operands, gates the s2p shift, launches div then mul.
// Latency start->res_valid = 2+SER_BITS+SIN_LAT+div wait+mul wait; result held until res_ready; start ignored while busy.
module datapath_seq_ctrl #(
  parameter int DATA_W   = 12,
  parameter int SER_BITS = 10,
  parameter int SIN_LAT  = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] c_in,
  output logic [DATA_W-1:0] a_q,
  output logic [DATA_W-1:0] b_q,
  output logic [DATA_W-1:0] c_q,
  output logic              shift_en,
  output logic              div_start,
  input  logic              div_done,
  output logic              mul_start,
  input  logic              mul_done,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        err
);

  localparam int CNT_MAX = (TIMEOUT > SER_BITS) ? ((TIMEOUT > SIN_LAT) ? TIMEOUT : SIN_LAT)
                                                : ((SER_BITS > SIN_LAT) ? SER_BITS : SIN_LAT);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SER_LAST = CNT_W'(SER_BITS - 1);
  localparam logic [CNT_W-1:0] SIN_LAST = CNT_W'((SIN_LAT > 0) ? SIN_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SINW, DIV, MUL, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W+1:0] divisor;
  logic [1:0]        err_nxt;

  // Two guard bits so a full-scale sum can never wrap to zero.
  assign divisor = {2'b00, a_q} + {2'b00, b_q} + {2'b00, c_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Done inputs are ignored while cnt==0, i.e. on the launch-pulse cycle.
  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    unique case (state)
      IDLE:  if (start) begin
               state_nxt = LOAD;
               err_nxt   = 2'd0;
             end
      LOAD:  if (divisor == '0) begin
               state_nxt = DONE;
               err_nxt   = 2'd1;
             end else begin
               state_nxt = SHIFT;
             end
      SHIFT: if (cnt == SER_LAST) state_nxt = (SIN_LAT == 0) ? DIV : SINW;
      SINW:  if (cnt == SIN_LAST) state_nxt = DIV;
      DIV:   if (cnt != '0 && div_done) begin
               state_nxt = MUL;
             end else if (cnt == TO_LAST) begin
               state_nxt = DONE;
               err_nxt   = 2'd2;
             end
      MUL:   if (cnt != '0 && mul_done) begin
               state_nxt = DONE;
             end else if (cnt == TO_LAST) begin
               state_nxt = DONE;
               err_nxt   = 2'd2;
             end
      DONE:  if (res_ready) begin
               state_nxt = IDLE;
               err_nxt   = 2'd0;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    shift_en  = (state == SHIFT);
    div_start = (state == DIV) && (cnt == '0);
    mul_start = (state == MUL) && (cnt == '0);
    res_valid = (state == DONE);
  end

  // One counter serves as bit index, sin wait and watchdog; it restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 2'd0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      err <= err_nxt;
      if (state == IDLE && start) begin
        a_q <= a_in;
        b_q <= b_in;
        c_q <= c_in;
      end
      if (state_nxt != state || state == IDLE || state == DONE) cnt <= '0;
      else                                                       cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Scoreboard bench for datapath_seq_ctrl: expectations queued at start, compared when res_valid appears.
module tb_datapath_seq_ctrl;

  localparam int DW  = 12;
  localparam int SER = 10;
  localparam int SIN = 1;
  localparam int TO  = 64;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] a_in, b_in, c_in;
  logic [DW-1:0] a_q, b_q, c_q;
  logic          shift_en, div_start, div_done, mul_start, mul_done;
  logic          busy, res_valid, res_ready;
  logic [1:0]    err;

  datapath_seq_ctrl #(.DATA_W(DW), .SER_BITS(SER), .SIN_LAT(SIN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .a_q(a_q), .b_q(b_q), .c_q(c_q),
    .shift_en(shift_en), .div_start(div_start), .div_done(div_done),
    .mul_start(mul_start), .mul_done(mul_done),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int err;
    int a;
    int lat;
    int nsh;
    int ndiv;
    int nmul;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input int obs, input int want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  // Cycle 0 = start sampled; 1 = LOAD; 2.. = SHIFT; DIV spends dly+1 cycles (launch + wait).
  function automatic exp_t model(input int a, input int b, input int c, input int dd, input int md);
    exp_t e;
    int   d0;
    d0    = 2 + SER + SIN;
    e.a   = a;
    if (a + b + c == 0) begin
      e.err = 1; e.lat = 2; e.nsh = 0; e.ndiv = 0; e.nmul = 0;
    end else begin
      e.nsh  = SER;
      e.ndiv = 1;
      if (dd < 1 || dd > TO - 1) begin
        e.err = 2; e.lat = d0 + TO; e.nmul = 0;
      end else if (md < 1 || md > TO - 1) begin
        e.err = 2; e.lat = d0 + dd + 1 + TO; e.nmul = 1;
      end else begin
        e.err = 0; e.lat = d0 + dd + 1 + md + 1; e.nmul = 1;
      end
    end
    return e;
  endfunction

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                        input int div_dly, input int mul_dly, input int rdy_dly, input bit spam);
    exp_t e, got_e;
    int   div_at, mul_at, nshift, ndiv, nmul, sh_first, sh_last, v_at, nvalid, v_err;
    bit   acc;
    e = model(int'(a), int'(b), int'(c), div_dly, mul_dly);
    got_e = e;
    sb.push_back(e);
    @(negedge clk);
    a_in = a; b_in = b; c_in = c; start = 1'b1; res_ready = 1'b0;
    div_at = -1000; mul_at = -1000; nshift = 0; ndiv = 0; nmul = 0;
    sh_first = -1; sh_last = -1; v_at = -1; nvalid = 0; v_err = 0; acc = 1'b0;
    for (int cyc = 1; cyc <= 600 && !acc; cyc++) begin
      @(negedge clk);
      start = spam;
      if (spam) begin
        a_in = DW'($urandom); b_in = DW'($urandom); c_in = DW'($urandom);
      end
      if (shift_en) begin
        nshift++;
        if (sh_first < 0) sh_first = cyc;
        sh_last = cyc;
      end
      if (div_start) begin ndiv++; div_at = cyc; end
      if (mul_start) begin nmul++; mul_at = cyc; end
      div_done = (div_dly >= 0) && (cyc == div_at + div_dly);
      mul_done = (mul_dly >= 0) && (cyc == mul_at + mul_dly);
      if (res_valid) begin
        if (v_at < 0) begin
          v_at = cyc;
          v_err = int'(err);
          if (sb.size() > 0) got_e = sb.pop_front();
          check_val("latency", v_at, got_e.lat);
          check_val("a_q", int'(a_q), got_e.a);
        end
        nvalid++;
        check_val("err", int'(err), got_e.err);
        check_val("err_stable", int'(err), v_err);
        res_ready = (cyc - v_at >= rdy_dly);
        acc = res_ready;
      end
    end
    check_val("accepted", int'(acc), 1);
    if (!acc) sb.delete();
    @(negedge clk);
    check_val("busy_after_accept", int'(busy), 0);
    check_val("valid_after_accept", int'(res_valid), 0);
    start = 1'b0; res_ready = 1'b0; div_done = 1'b0; mul_done = 1'b0;
    check_val("valid_cycles", nvalid, rdy_dly + 1);
    check_val("shift_count", nshift, got_e.nsh);
    if (got_e.nsh > 0) begin
      check_val("shift_first", sh_first, 2);
      check_val("shift_span", sh_last - sh_first + 1, got_e.nsh);
    end
    check_val("div_pulses", ndiv, got_e.ndiv);
    check_val("mul_pulses", nmul, got_e.nmul);
  endtask

  task automatic reset_mid_shift();
    @(negedge clk);
    a_in = 12'd100; b_in = 12'd200; c_in = 12'd300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check_val("t5_shift_before_rst", int'(shift_en), 1);
    #2 rst = 1'b1;
    #1;
    check_val("t5_shift_async", int'(shift_en), 0);
    check_val("t5_busy_async", int'(busy), 0);
    @(negedge clk);
    check_val("t5_no_result", int'(res_valid), 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; res_ready = 1'b0; div_done = 1'b0; mul_done = 1'b0;
    a_in = '0; b_in = '0; c_in = '0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_valid", int'(res_valid), 0);
    check_val("rst_shift", int'(shift_en), 0);
    check_val("rst_div_start", int'(div_start), 0);
    check_val("rst_mul_start", int'(mul_start), 0);
    check_val("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(12'd100, 12'd200, 12'd300, 26, 4, 0, 1'b0);   // nominal
    run_op(12'd0, 12'd0, 12'd0, 26, 4, 0, 1'b0);         // zero divisor
    run_op(12'd1, 12'd2, 12'd3, -1, 4, 0, 1'b0);         // divider timeout
    run_op(12'd5, 12'd5, 12'd5, 3, -1, 0, 1'b0);         // multiplier timeout
    run_op(12'd7, 12'd0, 12'd0, 0, 4, 0, 1'b0);          // done on launch cycle is ignored
    run_op(12'd1, 12'd1, 12'd1, TO - 1, TO - 1, 2, 1'b0); // done on last watchdog cycle
    run_op(12'h800, 12'h800, 12'h000, 5, 2, 0, 1'b0);    // sum wraps in DATA_W bits only
    run_op(12'hFFF, 12'd1, 12'd2, 10, 3, 1, 1'b1);       // start spammed while busy
    run_op(12'd9, 12'd8, 12'd7, 5, 5, 20, 1'b0);         // long backpressure
    reset_mid_shift();
    run_op(12'd100, 12'd200, 12'd300, 26, 4, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      run_op(DW'($urandom_range(1, 4095)), DW'($urandom_range(0, 4095)), DW'($urandom_range(0, 4095)),
             int'($urandom_range(1, 40)), int'($urandom_range(1, 20)), int'($urandom_range(0, 3)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
